serial_pwd_sender: RTL

SERIAL_PWD_SENDER -- requirements
Module: serial_pwd_sender

---
 rtl/serial_pwd_pkg.sv | 28 ++
 rtl/serial_pwd_sender_if.sv | 35 +++
 rtl/serial_pwd_sender_timeout_ctr.sv | 33 +++
 rtl/serial_pwd_sender.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/serial_pwd_pkg.sv
// Shared types and defaults for the serial password sender and the lock benches.
package serial_pwd_pkg;

    localparam int unsigned DEF_CODE_WIDTH     = 4;
    localparam int unsigned DEF_READY_TIMEOUT  = 10;
    localparam int unsigned DEF_RESULT_TIMEOUT = 8;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_SEND        = 3'd1,
        ST_GAP         = 3'd2,
        ST_WAIT_RESULT = 3'd3,
        ST_FINISH      = 3'd4
    } sender_state_e;

    // Sticky outcome of the most recent attempt.
    typedef struct packed {
        logic unlocked;
        logic incorrect;
        logic timeout;
    } sender_result_t;

    // Counter width able to hold 0 .. limit-1 (at least one bit).
    function automatic int unsigned ctr_width(input int unsigned limit);
        return (limit > 1) ? $clog2(limit) : 1;
    endfunction

endpackage

// File: rtl/serial_pwd_sender_if.sv
// Host control, serial link and lock verdict signals of the password sender.
interface serial_pwd_sender_if
    import serial_pwd_pkg::*;
#(
    parameter int unsigned CODE_WIDTH = DEF_CODE_WIDTH
);

    logic                  start;
    logic [CODE_WIDTH-1:0] code;
    logic                  serial_data;
    logic                  serial_valid;
    logic                  serial_ready;
    logic                  unlock;
    logic                  pwd_incorrect;
    logic                  busy;
    logic                  done;
    logic                  result_unlocked;
    logic                  result_incorrect;
    logic                  result_timeout;

    // Sender side.
    modport master (
        input  start, code, serial_ready, unlock, pwd_incorrect,
        output serial_data, serial_valid, busy, done,
               result_unlocked, result_incorrect, result_timeout
    );

    // Host / lock side.
    modport slave (
        output start, code, serial_ready, unlock, pwd_incorrect,
        input  serial_data, serial_valid, busy, done,
               result_unlocked, result_incorrect, result_timeout
    );

endinterface

// File: rtl/serial_pwd_sender_timeout_ctr.sv
// Cycle counter that flags when LIMIT enabled cycles have elapsed since clear.
module sender_timeout_ctr
    import serial_pwd_pkg::*;
#(
    parameter int unsigned LIMIT = DEF_READY_TIMEOUT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int unsigned     CW   = ctr_width(LIMIT);
    localparam logic [CW-1:0]   LAST = CW'(LIMIT - 1);

    logic [CW-1:0] cnt_q;
    logic          expired_q;

    // Count enabled cycles; expired_q is high during the LIMIT-th enabled cycle.
    always_ff @(posedge clk) begin
        if (reset || clear_i) begin
            cnt_q     <= '0;
            expired_q <= (LAST == '0);
        end else if (enable_i && !expired_q) begin
            cnt_q     <= cnt_q + CW'(1);
            expired_q <= ((cnt_q + CW'(1)) == LAST);
        end
    end

    assign expired_o = expired_q;

endmodule

// File: rtl/serial_pwd_sender.sv
// Sends a captured password MSB first over a valid/ready link and collects the lock verdict.
module serial_pwd_sender
    import serial_pwd_pkg::*;
#(
    parameter int unsigned CODE_WIDTH     = DEF_CODE_WIDTH,
    parameter int unsigned READY_TIMEOUT  = DEF_READY_TIMEOUT,
    parameter int unsigned RESULT_TIMEOUT = DEF_RESULT_TIMEOUT
) (
    input  logic                    clk,
    input  logic                    reset,
    serial_pwd_sender_if.master     bus
);

    localparam int unsigned BCW = $clog2(CODE_WIDTH + 1);

    sender_state_e         state_q;
    logic [CODE_WIDTH-1:0] shift_q;
    logic [BCW-1:0]        bits_q;
    logic                  valid_q;
    logic                  busy_q;
    logic                  done_q;
    sender_result_t        result_q;

    logic transfer_c;
    logic ready_clr_c;
    logic ready_en_c;
    logic ready_expired_c;
    logic result_clr_c;
    logic result_en_c;
    logic result_expired_c;

    // Handshake and timeout counter controls.
    assign transfer_c   = (state_q == ST_SEND) && valid_q && bus.serial_ready;
    assign ready_clr_c  = (state_q != ST_SEND);
    assign ready_en_c   = (state_q == ST_SEND) && !transfer_c;
    assign result_clr_c = (state_q != ST_WAIT_RESULT);
    assign result_en_c  = (state_q == ST_WAIT_RESULT);

    sender_timeout_ctr #(.LIMIT(READY_TIMEOUT)) u_ready_ctr (
        .clk       (clk),
        .reset     (reset),
        .clear_i   (ready_clr_c),
        .enable_i  (ready_en_c),
        .expired_o (ready_expired_c)
    );

    sender_timeout_ctr #(.LIMIT(RESULT_TIMEOUT)) u_result_ctr (
        .clk       (clk),
        .reset     (reset),
        .clear_i   (result_clr_c),
        .enable_i  (result_en_c),
        .expired_o (result_expired_c)
    );

    // Attempt FSM; every output is set on the transition into the state that owns it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            shift_q  <= '0;
            bits_q   <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        state_q  <= ST_SEND;
                        shift_q  <= bus.code;
                        bits_q   <= BCW'(CODE_WIDTH);
                        result_q <= '0;
                        valid_q  <= 1'b1;
                        busy_q   <= 1'b1;
                    end
                end
                ST_SEND: begin
                    // Lock rejection beats a same-cycle transfer.
                    if (bus.pwd_incorrect) begin
                        state_q            <= ST_FINISH;
                        valid_q            <= 1'b0;
                        result_q.incorrect <= 1'b1;
                        done_q             <= 1'b1;
                    end else if (transfer_c) begin
                        state_q <= ST_GAP;
                        valid_q <= 1'b0;
                        shift_q <= shift_q << 1;
                        bits_q  <= bits_q - BCW'(1);
                    end else if (ready_expired_c) begin
                        state_q          <= ST_FINISH;
                        valid_q          <= 1'b0;
                        result_q.timeout <= 1'b1;
                        done_q           <= 1'b1;
                    end
                end
                ST_GAP: begin
                    if (bus.pwd_incorrect) begin
                        state_q            <= ST_FINISH;
                        result_q.incorrect <= 1'b1;
                        done_q             <= 1'b1;
                    end else if (bits_q == '0) begin
                        state_q <= ST_WAIT_RESULT;
                    end else begin
                        state_q <= ST_SEND;
                        valid_q <= 1'b1;
                    end
                end
                ST_WAIT_RESULT: begin
                    // A rejection masks a simultaneous unlock.
                    if (bus.pwd_incorrect) begin
                        state_q            <= ST_FINISH;
                        result_q.incorrect <= 1'b1;
                        done_q             <= 1'b1;
                    end else if (bus.unlock) begin
                        state_q           <= ST_FINISH;
                        result_q.unlocked <= 1'b1;
                        done_q            <= 1'b1;
                    end else if (result_expired_c) begin
                        state_q          <= ST_FINISH;
                        result_q.timeout <= 1'b1;
                        done_q           <= 1'b1;
                    end
                end
                ST_FINISH: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.serial_data      = shift_q[CODE_WIDTH-1];
    assign bus.serial_valid     = valid_q;
    assign bus.busy             = busy_q;
    assign bus.done             = done_q;
    assign bus.result_unlocked  = result_q.unlocked;
    assign bus.result_incorrect = result_q.incorrect;
    assign bus.result_timeout   = result_q.timeout;

endmodule
